// File: rtl/dcache_victim_wb.sv
// Dirty-line writeback engine: reads a victim line from the 8 dcache word
// banks in one access, holds it in a local buffer so the refill path can reuse
// the RAM, and writes it to memory as one 8-beat AXI INCR burst.
module dcache_victim_wb #(
    parameter int              ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = ID_W'(1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_req,
    input  logic [31:0]     wb_addr,
    output logic            wb_ready,
    output logic            wb_captured,
    output logic            wb_done,
    input  logic [31:0]     snoop_addr,
    output logic            snoop_hit,
    output logic            ram_en,
    output logic [31:0]     ram_addr,
    input  logic [255:0]    ram_rdata,
    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic            awvalid,
    input  logic            awready,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_SEND,
        S_RESP
    } state_t;

    state_t         state_q, state_d;
    logic [26:0]    line_q, line_d;
    logic [255:0]   line_buf_q, line_buf_d;
    logic [2:0]     beat_q, beat_d;
    logic           aw_done_q, aw_done_d;
    logic           w_done_q, w_done_d;
    logic           aw_hs, w_hs;

    // Response ID and status carry no information for this engine, nor do the
    // byte-offset bits of the snoop address.
    logic unused_inputs;
    assign unused_inputs = ^{bid, bresp, snoop_addr[4:0]};

    // Control state, held line address and burst progress; reset abandons any burst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            line_q    <= '0;
            beat_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            beat_q    <= beat_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Line buffer contents are meaningless after reset, so it has no reset.
    always_ff @(posedge clk) begin
        line_buf_q <= line_buf_d;
    end

    // Next-state and handshake outputs; W runs alongside AW with no ordering between them.
    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        line_buf_d  = line_buf_q;
        beat_d      = beat_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        wb_ready    = 1'b0;
        wb_captured = 1'b0;
        wb_done     = 1'b0;
        ram_en      = 1'b0;
        awvalid     = 1'b0;
        wvalid      = 1'b0;
        bready      = 1'b0;
        aw_hs       = 1'b0;
        w_hs        = 1'b0;
        case (state_q)
            S_IDLE: begin
                wb_ready = 1'b1;
                if (wb_req) begin
                    ram_en  = 1'b1;
                    line_d  = wb_addr[31:5];
                    state_d = S_RD;
                end
            end
            S_RD: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                line_buf_d  = ram_rdata;
                wb_captured = 1'b1;
                aw_done_d   = 1'b0;
                w_done_d    = 1'b0;
                beat_d      = 3'd0;
                state_d     = S_SEND;
            end
            S_SEND: begin
                awvalid = !aw_done_q;
                wvalid  = !w_done_q;
                aw_hs   = awvalid && awready;
                w_hs    = wvalid && wready;
                if (aw_hs) begin
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        w_done_d = 1'b1;
                    end
                end
                if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && beat_q == 3'd7))) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    wb_done = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ram_addr  = wb_addr;
    assign awid      = AXI_ID;
    assign awaddr    = {line_q, 5'b0};
    assign awlen     = 8'd7;
    assign awsize    = 3'd2;
    assign awburst   = 2'b01;
    assign wdata     = line_buf_q[{beat_q, 5'b0} +: 32];
    assign wstrb     = 4'hF;
    assign wlast     = (beat_q == 3'd7);
    assign snoop_hit = (state_q != S_IDLE) && (snoop_addr[31:5] == line_q);

endmodule

// File: doc/dcache_victim_wb.md
Name: dcache_victim_wb

Overview:
- Dirty-line writeback engine downstream of the dcache data RAM banks (8 word banks, each indexed by addr[12:5], 1-cycle read latency).
- On a writeback request it:
  - reads the victim line from all 8 banks in one access;
  - latches the line into a 256-bit buffer;
  - drives an AXI3/AXI4 INCR burst of 8 x 32-bit beats to memory.
- The refill path may overwrite the RAM as soon as the line is captured, before memory acknowledges the write.

Parameters:
- AXI_ID, 4'd1, constant awid driven on every burst.
- ID_W, 4, width of awid/bid.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- wb_req  in  1  writeback request; sampled only when wb_ready=1
- wb_addr  in  32  victim line address; bits [4:0] ignored
- wb_ready  out  1  engine idle, can accept wb_req
- wb_captured  out  1  1-cycle pulse: line latched, RAM may be overwritten
- wb_done  out  1  1-cycle pulse: B response received
- snoop_addr  in  32  miss address from the dcache
- snoop_hit  out  1  busy && snoop_addr[31:5]==held line address
- ram_en  out  1  read enable to all 8 data banks
- ram_addr  out  32  bank address; equals wb_addr as latched
- ram_rdata  in  256  bank k word at [32k+31:32k], k=0..7
- awid  out  ID_W;  awaddr  out  32;  awlen  out  8;  awsize  out  3;  awburst  out  2
- awvalid  out  1;  awready  in  1
- wdata  out  32;  wstrb  out  4;  wlast  out  1;  wvalid  out  1;  wready  in  1
- bid  in  ID_W;  bresp  in  2;  bvalid  in  1;  bready  out  1

Behaviour:
- Reset (rst=0, asynchronous), outputs:
  - state=IDLE, wb_ready=1;
  - ram_en=0, awvalid=0, wvalid=0, bready=0;
  - wb_captured=0, wb_done=0, snoop_hit=0;
  - beat counter=0, buffer contents don't-care.
- States: IDLE -> RD -> CAP -> SEND -> RESP -> IDLE.
- IDLE:
  - wb_ready=1.
  - wb_req=1: latch {wb_addr[31:5],5'b0} into line_addr, assert ram_en for one cycle (combinational in this cycle, ram_addr=wb_addr), go RD.
  - wb_ready deasserts the cycle after acceptance.
- RD: ram_en=0; wait one cycle for the RAM output to become valid. Go CAP.
- CAP:
  - latch ram_rdata into buf, pulse wb_captured, clear aw_done, beat=0.
  - Go SEND.
  - ram_rdata is not sampled in any other state.
- SEND:
  - AW channel:
    - awvalid=1 until the awvalid&awready handshake, then aw_done=1 and awvalid drops next cycle.
    - awaddr=line_addr, awlen=7, awsize=2, awburst=2'b01, awid=AXI_ID.
  - W channel, issued concurrently with AW (no W-before-AW restriction):
    - wvalid=1, wdata=buf word[beat], wstrb=4'hF, wlast=(beat==7).
    - Each wvalid&wready handshake increments beat.
    - The handshake with beat==7 ends the burst.
  - Leave SEND only when aw_done (or AW handshake this cycle) and the last W handshake (this cycle or earlier) have both occurred. Go RESP.
  - awvalid/wvalid, once raised, must not drop or change payload before their handshake.
- RESP:
  - bready=1.
  - On bvalid: pulse wb_done, go IDLE; bresp value ignored.
  - wb_ready returns to 1 in the cycle after wb_done.
- snoop_hit:
  - Valid in every state except IDLE.
  - The refill path must stall a miss to a line that is being written back.
- Back-to-back requests: a new wb_req is accepted no earlier than the IDLE cycle after wb_done. Minimum period = 4 + max(AW,W) + B latency.
- Reset mid-burst: abandons the burst immediately (all valids drop), returns to IDLE. The interconnect is reset together with the engine.
- wb_req while not wb_ready: ignored; the requester holds it.

Test Plan:
- Single writeback, always-ready slave:
  - Stimulus: wb_addr=0x1234_5678, bank k holds 0xA000_000k.
  - Required:
    - ram_en in the accept cycle with ram_addr=0x1234_5678;
    - wb_captured 2 cycles later;
    - awaddr=0x1234_5660, awlen=7;
    - 8 beats in order 0xA0000000..0xA0000007, wlast on beat 8 only;
    - wb_done on bvalid.
- Backpressure:
  - Stimulus: awready delayed 5 cycles, wready toggling 1/0, bvalid 3 cycles after wlast.
  - Required: payloads stable while stalled, no beat lost or duplicated, wb_done exactly once.
- Early W: W handshakes complete before awready -> RESP is entered only after the AW handshake.
- Snoop:
  - During SEND: snoop_addr=0x1234_567C -> snoop_hit=1; snoop_addr=0x1234_5680 -> snoop_hit=0.
  - In IDLE: snoop_hit=0.
- Reset mid-burst:
  - Stimulus: assert rst after 3 beats.
  - Required: valids drop asynchronously, wb_ready=1.
  - Follow-up: a new request after reset produces a clean 8-beat burst.
- Request while busy: hold wb_req high through a burst -> second burst starts only after wb_done and uses the newly latched address.
